// File: rtl/serial_adder_if.sv
// Handshake bundle for serial_adder: operand channel (in_*, a, b, cin, sub)
// and result channel (out_*, sum, cout, ovf) plus busy status.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             busy;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, busy
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, busy
    );
endinterface

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: DIGIT bits per clock, WIDTH/DIGIT steps.
// Ports: clk, rst_n (async active-low), bus (serial_adder_if.slave).
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    serial_adder_if.slave bus
);
    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH) begin : g_bad_range
        $error("serial_adder: need 1 <= DIGIT <= WIDTH");
    end
    if (WIDTH % DIGIT != 0) begin : g_bad_div
        $error("serial_adder: WIDTH must be a multiple of DIGIT");
    end

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    logic [DIGIT:0]   slice;
    logic [WIDTH-1:0] sum_nxt;
    logic             msb_cin;

    // One DIGIT-wide ripple slice; bit DIGIT is the carry out.
    assign slice = {1'b0, a_q[DIGIT-1:0]}
                 + {1'b0, b_q[DIGIT-1:0]}
                 + {{DIGIT{1'b0}}, carry};

    // Carry into the slice MSB, recovered from the sum bit.
    assign msb_cin = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ slice[DIGIT-1];

    // New digits enter at the top so the result ends up in place.
    if (STEPS == 1) begin : g_one
        assign sum_nxt = slice[DIGIT-1:0];
    end else begin : g_many
        assign sum_nxt = {slice[DIGIT-1:0], sum_q[WIDTH-1:DIGIT]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            carry  <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q   <= bus.a;
                        // Subtract as A + ~B + 1.
                        b_q   <= bus.sub ? ~bus.b : bus.b;
                        carry <= bus.sub | bus.cin;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_q   <= a_q >> DIGIT;
                    b_q   <= b_q >> DIGIT;
                    sum_q <= sum_nxt;
                    carry <= slice[DIGIT];
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        cout_q <= slice[DIGIT];
                        ovf_q  <= msb_cin ^ slice[DIGIT];
                        state  <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: W8/D1, W4/D2 and W4/D4 instances
// compared against a signed/unsigned arithmetic reference.
module tb_serial_adder;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    serial_adder_if #(.WIDTH(8)) bus8 ();
    serial_adder_if #(.WIDTH(4)) bus42 ();
    serial_adder_if #(.WIDTH(4)) bus44 ();

    serial_adder #(.WIDTH(8), .DIGIT(1)) dut8 (
        .clk(clk), .rst_n(rst_n), .bus(bus8)
    );
    serial_adder #(.WIDTH(4), .DIGIT(2)) dut42 (
        .clk(clk), .rst_n(rst_n), .bus(bus42)
    );
    serial_adder #(.WIDTH(4), .DIGIT(4)) dut44 (
        .clk(clk), .rst_n(rst_n), .bus(bus44)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Returns {ovf, cout, sum} for a w-bit operation.
    function automatic int ref_res(int w, int a, int b, int cin, int sub);
        int m;
        int sa;
        int sb;
        int r;
        int sr;
        int co;
        int ov;
        m  = 1 << w;
        sa = (a >= m / 2) ? a - m : a;
        sb = (b >= m / 2) ? b - m : b;
        if (sub != 0) begin
            r  = a - b;
            co = (a >= b) ? 1 : 0;
            sr = sa - sb;
        end else begin
            r  = a + b + cin;
            co = (r >= m) ? 1 : 0;
            sr = sa + sb + cin;
        end
        r  = ((r % m) + m) % m;
        ov = (sr < -(m / 2) || sr >= m / 2) ? 1 : 0;
        return (ov << (w + 1)) | (co << w) | r;
    endfunction

    task automatic do8(input logic [7:0] a, input logic [7:0] b,
                       input logic cin, input logic sub, input int hold,
                       output logic [7:0] s);
        int lat;
        logic [31:0] exp;
        exp = ref_res(8, a, b, cin, sub);
        @(negedge clk);
        bus8.a         = a;
        bus8.b         = b;
        bus8.cin       = cin;
        bus8.sub       = sub;
        bus8.in_valid  = 1'b1;
        bus8.out_ready = (hold == 0);
        @(posedge clk);
        #1;
        bus8.in_valid = 1'b0;
        bus8.a        = 8'($urandom);
        bus8.b        = 8'($urandom);
        bus8.cin      = 1'($urandom);
        bus8.sub      = 1'($urandom);
        lat = 0;
        while (!bus8.out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("lat8", lat, 8);
        chk("res8", {22'b0, bus8.ovf, bus8.cout, bus8.sum}, exp);
        s = bus8.sum;
        for (int i = 0; i < hold; i++) begin
            if (i == 1) begin
                bus8.a        = 8'h11;
                bus8.b        = 8'h22;
                bus8.in_valid = 1'b1;
            end else begin
                bus8.in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            chk("hold8",
                {20'b0, bus8.out_valid, bus8.in_ready,
                 bus8.ovf, bus8.cout, bus8.sum},
                {20'b0, 2'b10, exp[9:0]});
        end
        bus8.in_valid  = 1'b0;
        bus8.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("hs8", {30'b0, bus8.in_ready, bus8.out_valid}, 32'h2);
    endtask

    logic [7:0] s8;
    logic       seen;
    int         l2;
    int         l4;
    logic [31:0] g2;
    logic [31:0] g4;
    int         e;

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus8.in_valid = 0; bus8.a = 0; bus8.b = 0;
        bus8.cin = 0; bus8.sub = 0; bus8.out_ready = 1;
        bus42.in_valid = 0; bus42.a = 0; bus42.b = 0;
        bus42.cin = 0; bus42.sub = 0; bus42.out_ready = 1;
        bus44.in_valid = 0; bus44.a = 0; bus44.b = 0;
        bus44.cin = 0; bus44.sub = 0; bus44.out_ready = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_rdy", {31'b0, bus8.in_ready}, 1);
        chk("rst_ov", {31'b0, bus8.out_valid}, 0);
        chk("rst_busy", {31'b0, bus8.busy}, 0);
        chk("rst_res", {22'b0, bus8.ovf, bus8.cout, bus8.sum}, 0);

        do8(8'hFF, 8'h01, 1'b0, 1'b0, 0, s8);
        chk("add_ff01", {24'b0, s8}, 32'h00);
        do8(8'h7F, 8'h00, 1'b1, 1'b0, 0, s8);
        chk("add_7f00", {22'b0, bus8.ovf, bus8.cout, s8}, 32'h280);
        do8(8'h05, 8'h07, 1'b1, 1'b1, 0, s8);
        chk("sub_0507", {24'b0, s8}, 32'hFE);
        do8(8'h80, 8'h01, 1'b1, 1'b1, 0, s8);
        chk("sub_8001", {22'b0, bus8.ovf, bus8.cout, s8}, 32'h37F);

        do8(8'h3C, 8'h45, 1'b0, 1'b0, 10, s8);
        chk("bp_res", {24'b0, s8}, 32'h81);
        do8(8'h0A, 8'h03, 1'b0, 1'b1, 0, s8);
        chk("bp_next", {24'b0, s8}, 32'h07);

        @(negedge clk);
        bus8.a = 8'h33; bus8.b = 8'h44; bus8.sub = 0; bus8.cin = 0;
        bus8.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus8.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_ov", {31'b0, bus8.out_valid}, 0);
        chk("arst_busy", {31'b0, bus8.busy}, 0);
        chk("arst_rdy", {31'b0, bus8.in_ready}, 1);
        chk("arst_sum", {24'b0, bus8.sum}, 0);
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (bus8.out_valid) seen = 1'b1;
        end
        chk("arst_nov", {31'b0, seen}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        do8(8'h10, 8'h20, 1'b0, 1'b0, 0, s8);
        chk("post_rst", {24'b0, s8}, 32'h30);

        for (int n = 0; n < 150; n++) begin
            do8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
                int'($urandom_range(0, 3)), s8);
        end

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    for (int s = 0; s < 2; s++) begin
                        @(negedge clk);
                        bus42.a = 4'(a); bus42.b = 4'(b);
                        bus42.cin = 1'(c); bus42.sub = 1'(s);
                        bus44.a = 4'(a); bus44.b = 4'(b);
                        bus44.cin = 1'(c); bus44.sub = 1'(s);
                        bus42.in_valid = 1'b1;
                        bus44.in_valid = 1'b1;
                        @(posedge clk);
                        #1;
                        bus42.in_valid = 1'b0;
                        bus44.in_valid = 1'b0;
                        l2 = 15;
                        l4 = 15;
                        g2 = 0;
                        g4 = 0;
                        for (int k = 1; k <= 6; k++) begin
                            @(posedge clk);
                            #1;
                            if (bus42.out_valid && l2 == 15) begin
                                l2 = k;
                                g2 = {26'b0, bus42.ovf, bus42.cout, bus42.sum};
                            end
                            if (bus44.out_valid && l4 == 15) begin
                                l4 = k;
                                g4 = {26'b0, bus44.ovf, bus44.cout, bus44.sum};
                            end
                        end
                        e = ref_res(4, a, b, c, s);
                        chk("ex_d2", g2 | (l2 << 6), e | (2 << 6));
                        chk("ex_d4", g4 | (l4 << 6), e | (1 << 6));
                    end
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised, multi-cycle adder/subtractor with valid/ready handshakes on both sides.
- Processes DIGIT bits per clock through a DIGIT-bit ripple-carry slice, so a wide add costs little area in exchange for WIDTH/DIGIT cycles of latency.
- Next generation of the team's fixed 4-bit combinational ripple adder: adds carry-in, carry-out, subtract mode and signed overflow.
- Sits between operand producers and result consumers in datapaths where area matters more than throughput.

Parameters:
- WIDTH, 8: operand and result width in bits; must be >= 1.
- DIGIT, 1: bits processed per cycle; 1 <= DIGIT <= WIDTH. WIDTH % DIGIT must be 0 (elaboration error otherwise).
- STEPS (localparam) = WIDTH/DIGIT.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands present on a, b, cin, sub.
- in_ready  output  1  block can accept an operation.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in for add; ignored when sub=1.
- sub  input  1  0: A+B+cin; 1: A-B.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result, low WIDTH bits.
- cout  output  1  carry-out of MSB (for sub: 1 = no borrow).
- ovf  output  1  two's-complement signed overflow.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset value: state IDLE; step counter, carry, operand registers, sum, cout, ovf all 0; in_ready=1, out_valid=0, busy=0.
- Reset mid-operation (any state): abort immediately and return to reset values. No partial result is ever presented.
- All outputs are driven from registers or decoded from state; no combinational path from inputs to outputs.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: latch a; latch b (sub=0) or ~b (sub=1); initial carry = cin (sub=0) or 1 (sub=1); counter=0; go to RUN.
  - a, b, cin, sub are sampled only on this accept edge.
- RUN:
  - in_ready=0.
  - Each cycle, add the low DIGIT bits of the A and B shift registers plus carry.
  - Shift the DIGIT result bits into the top of the sum register. Right-shift the operand registers by DIGIT. Update carry.
  - On the final step (counter==STEPS-1): register cout = final carry; register ovf = carry into MSB XOR carry out of MSB; go to DONE.
- DONE:
  - out_valid=1; sum, cout, ovf held stable until out_valid & out_ready.
  - On the handshake edge: go to IDLE.
  - in_ready is 0 in DONE, so a new accept occurs no earlier than the cycle after the result handshake.
- Latency: accept at edge k gives out_valid=1 after edge k+STEPS.
- Minimum initiation interval: STEPS+2 cycles with out_ready held high.
- sum contents are defined only while out_valid=1; they may change during RUN.
- in_valid while in_ready=0: ignored; no queuing, no error flag.
- Arithmetic: all results are modulo 2^WIDTH.
  - For sub=1, sum = A-B mod 2^WIDTH and cout = (A >= B unsigned).
  - ovf is computed the same way in both modes.
- Degenerate case: DIGIT == WIDTH (STEPS=1) must work, with 1 RUN cycle.

Test Plan:
- Reset: hold rst_n=0, then release → in_ready=1, out_valid=0, busy=0, sum=0, cout=0, ovf=0. Assert rst_n=0 asynchronously mid-cycle → outputs clear without waiting for a clk edge.
- Add with carry (WIDTH=8, DIGIT=1): a=0xFF, b=0x01, cin=0 → out_valid 8 cycles after accept; sum=0x00, cout=1, ovf=0. Repeat with a=0x7F, b=0x00, cin=1 → sum=0x80, cout=0, ovf=1.
- Subtract (WIDTH=8, DIGIT=1): a=0x05, b=0x07, sub=1 → sum=0xFE, cout=0, ovf=0. Then a=0x80, b=0x01, sub=1 → sum=0x7F, cout=1, ovf=1. Assert cin=1 on both; it must have no effect.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid → sum/cout/ovf stable, in_ready=0. Pulse in_valid with new operands → ignored. Raise out_ready → in_ready=1 on the next cycle, and the next result reflects only the later-accepted operands.
- Reset during RUN: assert rst_n=0 at RUN step 3 → no out_valid is produced. After release, a=0x10, b=0x20 → sum=0x30.
- Exhaustive (WIDTH=4, DIGIT=2 and DIGIT=4): all 256 (a,b) pairs × cin × sub, compared against a behavioural model → zero mismatches. Latency is exactly STEPS cycles in every case.
